pulse_handshake_tx: RTL and testbench

//  Source-side (transmit) end of a 4-phase req/ack handshake that moves single-cycle event

---
 rtl/pulse_handshake_pkg.sv | 24 ++
 rtl/sync_ff_chain.sv | 33 +++
 rtl/pulse_handshake_tx.sv | 139 +++++++++++++
 tb/tb_pulse_handshake_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_handshake_pkg.sv
// rtl/pulse_handshake_pkg.sv - shared types and helpers for the pulse handshake blocks
// Purpose: handshake state encoding, minimum synchroniser depth, counter sizing helper.
// Ports: none (package).
package pulse_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_state_t;

    localparam int MIN_SYNC_STAGES = 2;

    // Bits needed to hold values 0..max_val; never less than one.
    function automatic int cnt_bits(input int max_val);
        int b;
        b = 1;
        while ((1 << b) <= max_val) begin
            b = b + 1;
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// rtl/sync_ff_chain.sv - N-flop level synchroniser with synchronous reset
// Purpose: bring an asynchronous level into clk; output is the last stage.
// Ports:
//   clk    in  1  destination clock
//   reset  in  1  synchronous, active-high; clears every stage
//   d      in  1  asynchronous level
//   q      out 1  synchronised level, STAGES cycles of latency
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff_chain: STAGES must be at least 2");
    end

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// rtl/pulse_handshake_tx.sv - transmit end of a 4-phase req/ack pulse handshake
// Purpose: turn single-cycle pulses into a held req level for another clock domain,
//          buffer one pending event, count dropped events, flag stalled requests.
// Ports:
//   clk          in  1            block clock
//   reset        in  1            synchronous, active-high
//   pulse_in     in  1            event strobe, one cycle per event
//   ack_async    in  1            ack level from the destination domain
//   req_out      out 1            registered request level
//   busy         out 1            handshake active or an event pending
//   dropped      out 1            one-cycle strobe: a pulse was discarded
//   drop_count   out COUNT_WIDTH  saturating discarded-pulse count
//   timeout_err  out 1            sticky: a request waited TIMEOUT_CYCLES without ack
module pulse_handshake_tx
    import pulse_handshake_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pulse_in,
    input  logic                   ack_async,
    output logic                   req_out,
    output logic                   busy,
    output logic                   dropped,
    output logic [COUNT_WIDTH-1:0] drop_count,
    output logic                   timeout_err
);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("pulse_handshake_tx: SYNC_STAGES below minimum");
    end
    if (COUNT_WIDTH < 1) begin : g_bad_count
        $error("pulse_handshake_tx: COUNT_WIDTH must be at least 1");
    end

    localparam int TW = cnt_bits(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    hs_state_t     state;
    hs_state_t     state_n;
    logic          pending;
    logic          pending_n;
    logic          drop_n;
    logic          ack_sync;
    logic [TW-1:0] tmo_cnt;

    // Next-state helpers: consume = the pending slot starts this REQ,
    // direct = pulse_in itself starts this REQ (so it never enters the slot).
    logic consume;
    logic direct;
    logic held;
    logic incoming;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack_async),
        .q     (ack_sync)
    );

    always_comb begin
        state_n = state;
        consume = 1'b0;
        direct  = 1'b0;
        case (state)
            IDLE: begin
                // Waiting for ack_sync low also recovers from a local reset
                // taken while the far side still held ack.
                if (!ack_sync && (pulse_in || pending)) begin
                    state_n = REQ;
                    consume = pending;
                    direct  = !pending;
                end
            end
            REQ: begin
                if (ack_sync) begin
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_sync) begin
                    if (pending) begin
                        state_n = REQ;
                        consume = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A pulse arriving while the slot is freed in the same cycle refills it.
        held      = pending && !consume;
        incoming  = pulse_in && !direct;
        pending_n = held || incoming;
        drop_n    = held && incoming;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            req_out     <= 1'b0;
            busy        <= 1'b0;
            dropped     <= 1'b0;
            drop_count  <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            req_out <= (state_n == REQ);
            busy    <= (state_n != IDLE) || pending_n;
            dropped <= drop_n;

            if (drop_n && (drop_count != '1)) begin
                drop_count <= drop_count + COUNT_WIDTH'(1);
            end

            // Counter restarts on each REQ entry and parks at TMO_MAX so the
            // error is raised once per stalled request.
            if ((state_n == REQ) && (state != REQ)) begin
                tmo_cnt <= '0;
            end else if ((state == REQ) && (TIMEOUT_CYCLES != 0) && (tmo_cnt != TMO_MAX)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                if ((tmo_cnt + TW'(1)) == TMO_MAX) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// tb/tb_pulse_handshake_tx.sv - scoreboard bench for pulse_handshake_tx
module tb_pulse_handshake_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pulse_in = 1'b0;
    logic       ack_async;
    logic       req_out;
    logic       busy;
    logic       dropped;
    logic [1:0] drop_count;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int rel = 0;

    int exp_rise[$];
    int exp_fall[$];
    int exp_drop[$];

    logic far_en = 1'b1;
    logic far_ack = 1'b0;
    logic man_ack = 1'b0;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    logic req_q = 1'b0;

    assign ack_async = far_en ? far_ack : man_ack;

    pulse_handshake_tx #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16),
        .COUNT_WIDTH    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .ack_async   (ack_async),
        .req_out     (req_out),
        .busy        (busy),
        .dropped     (dropped),
        .drop_count  (drop_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, rel);
        end
    endtask

    // Far side: ack 3 clk after seeing req high, release 3 clk after req low.
    always begin
        @(posedge clk);
        #2;
        if (!far_en) begin
            hi_cnt  = 0;
            lo_cnt  = 0;
            far_ack = 1'b0;
        end else if (req_out && !far_ack) begin
            lo_cnt = 0;
            hi_cnt++;
            if (hi_cnt == 3) far_ack = 1'b1;
        end else if (!req_out && far_ack) begin
            hi_cnt = 0;
            lo_cnt++;
            if (lo_cnt == 3) far_ack = 1'b0;
        end else begin
            hi_cnt = 0;
            lo_cnt = 0;
        end
    end

    // Scoreboard: every req edge and drop strobe must match a queued expectation.
    always @(negedge clk) begin
        if (req_out && !req_q) begin
            if (exp_rise.size() == 0) check_eq("rise_unexpected", 1, 0);
            else check_eq("rise_cycle", rel, exp_rise.pop_front());
        end
        if (!req_out && req_q) begin
            if (exp_fall.size() == 0) check_eq("fall_unexpected", 1, 0);
            else check_eq("fall_cycle", rel, exp_fall.pop_front());
        end
        if (dropped) begin
            if (exp_drop.size() == 0) check_eq("drop_unexpected", 1, 0);
            else check_eq("drop_cycle", rel, exp_drop.pop_front());
        end
        req_q = req_out;
    end

    task automatic reset_dut();
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
        man_ack  = 1'b0;
        far_en   = 1'b1;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_req_out", req_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_dropped", dropped, 0);
        check_eq("rst_drop_count", drop_count, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
    endtask

    task automatic run(input int id, input logic [63:0] mask);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            rel      = k;
            pulse_in = mask[k];
            if (id == 5) begin
                if (k == 26) check_eq("tmo_before", timeout_err, 0);
                if (k == 27) check_eq("tmo_set", timeout_err, 1);
                if (k == 39) check_eq("tmo_req_held", req_out, 1);
                if (k == 40) far_en = 1'b1;
            end
            if (id == 6) begin
                man_ack = (k >= 12) && (k < 20);
                reset   = (k == 13);
                if (k == 14) check_eq("midreq_rst_req", req_out, 0);
                if (k == 18) check_eq("pending_busy", busy, 1);
                if (k == 22) begin
                    check_eq("gate_idle", req_out, 0);
                    far_en = 1'b1;
                end
            end
        end
        pulse_in = 1'b0;
    endtask

    task automatic end_checks(input int dc, input int tmo);
        check_eq("rise_left", exp_rise.size(), 0);
        check_eq("fall_left", exp_fall.size(), 0);
        check_eq("drop_left", exp_drop.size(), 0);
        check_eq("end_busy", busy, 0);
        check_eq("end_drop_count", drop_count, dc);
        check_eq("end_timeout_err", timeout_err, tmo);
        exp_rise.delete();
        exp_fall.delete();
        exp_drop.delete();
    endtask

    initial begin
        // 1: single event
        reset_dut();
        exp_rise = '{11};
        exp_fall = '{16};
        run(1, 64'h1 << 10);
        end_checks(0, 0);

        // 2: second pulse buffered, follows RELEASE directly
        reset_dut();
        exp_rise = '{11, 21};
        exp_fall = '{16, 26};
        run(2, (64'h1 << 10) | (64'h1 << 14));
        end_checks(0, 0);

        // 3: overflow while pending
        reset_dut();
        exp_rise = '{11, 21};
        exp_fall = '{16, 26};
        exp_drop = '{14};
        run(3, (64'h1 << 10) | (64'h3 << 12));
        end_checks(1, 0);

        // 4: five drops saturate a 2-bit counter
        reset_dut();
        exp_rise = '{11, 21};
        exp_fall = '{16, 26};
        exp_drop = '{13, 14, 15, 16, 17};
        run(4, 64'h7F << 10);
        end_checks(3, 0);

        // 5: timeout with late ack
        reset_dut();
        far_en = 1'b0;
        exp_rise = '{11};
        exp_fall = '{45};
        run(5, 64'h1 << 10);
        end_checks(0, 1);

        // 6: reset mid-REQ while ack held high
        reset_dut();
        far_en = 1'b0;
        exp_rise = '{11, 23};
        exp_fall = '{14, 28};
        run(6, (64'h1 << 10) | (64'h1 << 17));
        end_checks(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
